stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_pkg.sv | 7 +
 rtl/stopwatch_ctrl_debounce.sv | 41 ++++
 rtl/stopwatch_ctrl.sv | 65 ++++++
 3 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_ctrl_pkg: shared FSM state encoding and default timing parameters
package stopwatch_ctrl_pkg;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_PAUSE = 2'd1, ST_ADJUST = 2'd2} state_e;
  localparam int DB_CYCLES_DEF = 1_000_000;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W = 24;
endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// debounce: synchronizer plus debouncer; in raw, out debounced level and one-cycle rise
module debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic lvl_q, lvl_d, rise_q, rise_d, samp, hit;
  assign samp = sync_q[SYNC_STAGES-1];
  assign level = lvl_q;
  assign rise = rise_q;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
    hit = samp != lvl_q && cnt_q == CNT_LAST;
    cnt_d = (samp == lvl_q || hit) ? '0 : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    lvl_d = hit ? samp : lvl_q;
    rise_d = hit & samp;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      lvl_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      rise_q <= rise_d;
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced buttons drive RUN/PAUSE/ADJUST FSM; out paused, clr, set_pulse, adj, state
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause_raw,
  input  logic       btn_clear_raw,
  input  logic       btn_set_raw,
  input  logic       sw_adj_raw,
  output logic       paused,
  output logic       clr,
  output logic       set_pulse,
  output logic       adj,
  output logic [1:0] state
);
  logic pause_rise, clear_rise, set_rise, adj_lvl;
  logic pause_lvl_unused, clear_lvl_unused, set_lvl_unused, adj_rise_unused;
  state_e state_q, state_d;
  logic paused_q, paused_d, clr_q, clr_d, set_q, set_d, adj_q, adj_d;
  debounce #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_pause (
    .clk(clk), .rst(rst), .raw(btn_pause_raw), .level(pause_lvl_unused), .rise(pause_rise));
  debounce #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_clear (
    .clk(clk), .rst(rst), .raw(btn_clear_raw), .level(clear_lvl_unused), .rise(clear_rise));
  debounce #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_set (
    .clk(clk), .rst(rst), .raw(btn_set_raw), .level(set_lvl_unused), .rise(set_rise));
  debounce #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_adj (
    .clk(clk), .rst(rst), .raw(sw_adj_raw), .level(adj_lvl), .rise(adj_rise_unused));
  always_comb begin
    state_d = ST_PAUSE;
    case (state_q)
      ST_RUN:    state_d = adj_lvl ? ST_ADJUST : pause_rise ? ST_PAUSE : ST_RUN;
      ST_PAUSE:  state_d = adj_lvl ? ST_ADJUST : pause_rise ? ST_RUN : ST_PAUSE;
      ST_ADJUST: state_d = adj_lvl ? ST_ADJUST : ST_PAUSE;
      default:   state_d = ST_PAUSE;
    endcase
    paused_d = state_d != ST_RUN;
    adj_d = state_d == ST_ADJUST;
    clr_d = clear_rise;
    set_d = set_rise && state_q == ST_ADJUST;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_PAUSE;
      paused_q <= 1'b1;
      adj_q <= 1'b0;
      clr_q <= 1'b0;
      set_q <= 1'b0;
    end else begin
      state_q <= state_d;
      paused_q <= paused_d;
      adj_q <= adj_d;
      clr_q <= clr_d;
      set_q <= set_d;
    end
  end
  assign paused = paused_q;
  assign adj = adj_q;
  assign clr = clr_q;
  assign set_pulse = set_q;
  assign state = state_q;
endmodule
